// File: rtl/l2_memory_responder.sv
// Single-outstanding L2 block responder: round-robin request arbitration, fixed-latency read, preload port.
// Optional macro L2_RESPONDER_REQUEST_COUNT_EN enables the completed-response counter on REQUEST_COUNT.
module l2_memory_responder #(
  parameter int NUM_PORTS           = 2,
  parameter int BLOCK_ADDRESS_WIDTH = 26,
  parameter int BLOCK_WIDTH         = 512,
  parameter int DEPTH_BLOCKS        = 4,
  parameter int LATENCY             = 2
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [NUM_PORTS-1:0]                     ADDRESS_VALID,
  output logic [NUM_PORTS-1:0]                     ADDRESS_READY,
  input  logic [NUM_PORTS*BLOCK_ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [NUM_PORTS-1:0]                     DATA_VALID,
  input  logic [NUM_PORTS-1:0]                     DATA_READY,
  output logic [BLOCK_WIDTH-1:0]                   DATA,
  input  logic                                     LOAD_VALID,
  input  logic [BLOCK_ADDRESS_WIDTH-1:0]           LOAD_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0]                   LOAD_DATA,
  output logic [31:0]                              REQUEST_COUNT
);

  localparam int IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e                 state_q;
  logic [PORT_W-1:0]      last_q;
  logic [PORT_W-1:0]      port_q;
  logic [IDX_W-1:0]       index_q;
  logic [CNT_W-1:0]       wait_q;
  logic [BLOCK_WIDTH-1:0] data_q;
  logic [NUM_PORTS-1:0]   valid_q;
  logic [BLOCK_WIDTH-1:0] mem_q [DEPTH_BLOCKS];

  logic [NUM_PORTS-1:0]   grant;
  logic [PORT_W-1:0]      win_port;
  logic [PORT_W-1:0]      cand_p;
  logic [IDX_W-1:0]       win_index;
  logic                   found;
  logic                   accept;
  logic                   unused_bits;
  int                     cand;

  // Round-robin search begins one past the most recently granted port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant    = '0;
    win_port = last_q;
    cand_p   = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_p = PORT_W'(cand);
      if (!found && ADDRESS_VALID[cand_p]) begin
        found         = 1'b1;
        win_port      = cand_p;
        grant[cand_p] = 1'b1;
      end
    end
  end

  assign win_index     = ADDRESS[win_port*BLOCK_ADDRESS_WIDTH +: IDX_W];
  assign ADDRESS_READY = (state_q == IDLE && !RST) ? grant : '0;
  assign accept        = |ADDRESS_READY;

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q <= IDLE;
      last_q  <= PORT_W'(NUM_PORTS - 1);
      port_q  <= '0;
      index_q <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q  <= win_port;
            index_q <= win_index;
            last_q  <= win_port;
            wait_q  <= CNT_W'(LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wait_q <= wait_q - CNT_W'(1);
          if (wait_q == CNT_W'(1)) begin
            data_q  <= mem_q[index_q];
            valid_q <= NUM_PORTS'(1) << port_q;
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          if (DATA_READY[port_q]) begin
            valid_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A same-edge load lands after the response read above, so the old block is returned.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; preloaded contents survive RST.
    if (LOAD_VALID) mem_q[LOAD_ADDRESS[IDX_W-1:0]] <= LOAD_DATA;
  end

  assign DATA       = data_q;
  assign DATA_VALID = valid_q;

`ifdef L2_RESPONDER_REQUEST_COUNT_EN
  logic [31:0] req_count_q;

  always_ff @(posedge CLK) begin
    if (RST) req_count_q <= '0;
    else if (state_q == RESPOND && DATA_READY[port_q]) req_count_q <= req_count_q + 32'd1;
  end

  assign REQUEST_COUNT = req_count_q;
`else
  assign REQUEST_COUNT = '0;
`endif

  // Upper address bits alias onto the low index and are intentionally ignored.
  assign unused_bits = ^{ADDRESS, LOAD_ADDRESS};

endmodule

// File: tb/tb_l2_memory_responder.sv
// Scoreboard bench for l2_memory_responder: directed scenarios then randomized traffic
// against a transaction-level model (arbitration order, delayed read-before-write lookup).
module tb_l2_memory_responder;

  localparam int N     = 2;
  localparam int BAW   = 26;
  localparam int BW    = 512;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic             CLK;
  logic             RST;
  logic [N-1:0]     ADDRESS_VALID;
  logic [N-1:0]     ADDRESS_READY;
  logic [N*BAW-1:0] ADDRESS;
  logic [N-1:0]     DATA_VALID;
  logic [N-1:0]     DATA_READY;
  logic [BW-1:0]    DATA;
  logic             LOAD_VALID;
  logic [BAW-1:0]   LOAD_ADDRESS;
  logic [BW-1:0]    LOAD_DATA;
  logic [31:0]      REQUEST_COUNT;

  l2_memory_responder #(
    .NUM_PORTS(N), .BLOCK_ADDRESS_WIDTH(BAW), .BLOCK_WIDTH(BW),
    .DEPTH_BLOCKS(DEPTH), .LATENCY(LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .ADDRESS_VALID(ADDRESS_VALID), .ADDRESS_READY(ADDRESS_READY), .ADDRESS(ADDRESS),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .DATA(DATA),
    .LOAD_VALID(LOAD_VALID), .LOAD_ADDRESS(LOAD_ADDRESS), .LOAD_DATA(LOAD_DATA),
    .REQUEST_COUNT(REQUEST_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  longint edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Round-robin rule: first requesting port after the last granted one, or -1.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  typedef struct { int port; logic [BW-1:0] data; longint vis; } exp_t;
  typedef struct { int port; int idx; longint rd; } pend_t;

  exp_t          exp_q[$];
  pend_t         pend_q[$];
  int            grant_log[$];
  logic [BW-1:0] model_mem [DEPTH];
  bit            busy = 0;
  bit            resp_active = 0;
  int            resp_port = 0;
  longint        resp_vis = 0;
  int            last_port = N - 1;
  logic [31:0]   model_cnt = '0;

  // Reference model: sampled mid-cycle, describes what the coming rising edge does.
  always @(negedge CLK) begin
    int            w;
    logic [N-1:0]  exp_ready;
    logic [BAW-1:0] a;
    exp_t          e;
    pend_t         pd;
    exp_ready = '0;
    w = rr_pick(ADDRESS_VALID, last_port);
    if (!RST && !busy && w >= 0) exp_ready[w] = 1'b1;
    check("address_ready", ADDRESS_READY, exp_ready);
`ifdef L2_RESPONDER_REQUEST_COUNT_EN
    check("request_count", REQUEST_COUNT, model_cnt);
`else
    check("request_count", REQUEST_COUNT, 0);
`endif
    if (RST) begin
      pend_q.delete();
      busy        = 0;
      resp_active = 0;
      last_port   = N - 1;
      model_cnt   = '0;
    end else begin
      if (resp_active && resp_vis <= edge_n && DATA_READY[resp_port]) begin
        resp_active = 0;
        busy        = 0;
        model_cnt   = model_cnt + 32'd1;
      end else if (exp_ready != 0 && ADDRESS_READY === exp_ready) begin
        a       = ADDRESS[w*BAW +: BAW];
        pd.port = w;
        pd.idx  = int'(a % DEPTH);
        pd.rd   = edge_n + 1 + LAT;
        pend_q.push_back(pd);
        grant_log.push_back(w);
        last_port = w;
        busy      = 1;
      end
      for (int i = pend_q.size() - 1; i >= 0; i--) begin
        if (pend_q[i].rd == edge_n + 1) begin
          e.port = pend_q[i].port;
          e.data = model_mem[pend_q[i].idx];
          e.vis  = edge_n + 1;
          exp_q.push_back(e);
          resp_active = 1;
          resp_port   = e.port;
          resp_vis    = e.vis;
          pend_q.delete(i);
        end
      end
    end
    if (LOAD_VALID) model_mem[int'(LOAD_ADDRESS % DEPTH)] = LOAD_DATA;
  end

  // Monitor: pops an expectation when a response appears and checks it every cycle it is held.
  bit   have_cur = 0;
  exp_t cur;
  always @(negedge CLK) begin
    if (DATA_VALID != 0) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          check("unexpected_data_valid", DATA_VALID, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          check("response_latency", 64'(edge_n), 64'(cur.vis));
        end
      end
      if (have_cur) begin
        check("data_valid_port", DATA_VALID, N'(1) << cur.port);
        check("data", DATA, cur.data);
        if ((DATA_VALID & DATA_READY) != 0) have_cur = 0;
      end
    end else if (have_cur) begin
      check("data_valid_dropped", DATA_VALID, N'(1) << cur.port);
      have_cur = 0;
    end
    if (RST) have_cur = 0;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    ADDRESS_VALID = '0;
    DATA_READY    = '1;
    LOAD_VALID    = 1'b0;
    repeat (8) step();
  endtask

  task automatic wait_valid(input int p);
    int k;
    k = 0;
    @(negedge CLK);
    while (!DATA_VALID[p] && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("wait_valid_timeout", DATA_VALID[p], 1);
  endtask

  logic [BW-1:0] pre [DEPTH];
  logic [BW-1:0] new_blk;
  int            s;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; ADDRESS_VALID = '0; ADDRESS = '0; DATA_READY = '1;
    LOAD_VALID = 1'b0; LOAD_ADDRESS = '0; LOAD_DATA = '0;
    repeat (3) step();
    @(negedge CLK);
    check("rst_data_valid", DATA_VALID, 0);
    check("rst_data", DATA, 0);
    check("rst_count", REQUEST_COUNT, 0);
    check("rst_address_ready", ADDRESS_READY, 0);
    step();
    RST = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = rand_block();
      LOAD_VALID = 1'b1; LOAD_ADDRESS = BAW'(i); LOAD_DATA = pre[i];
      step();
    end
    LOAD_VALID = 1'b0;

    // Single request: response exactly LAT edges after acceptance, one cycle wide.
    ADDRESS[0 +: BAW] = BAW'(1); ADDRESS_VALID = 2'b01;
    step();
    ADDRESS_VALID = '0;
    step(); step();
    @(negedge CLK);
    check("single_valid", DATA_VALID, 2'b01);
    check("single_data", DATA, pre[1]);
    step(); step();
    @(negedge CLK);
    check("single_valid_dropped", DATA_VALID, 0);
`ifdef L2_RESPONDER_REQUEST_COUNT_EN
    check("single_count", REQUEST_COUNT, 1);
`else
    check("single_count", REQUEST_COUNT, 0);
`endif

    // Contention straight out of reset: grants alternate starting at port 0.
    RST = 1'b1; step(); RST = 1'b0;
    s = grant_log.size();
    ADDRESS[0 +: BAW] = BAW'($urandom); ADDRESS[BAW +: BAW] = BAW'($urandom);
    ADDRESS_VALID = 2'b11;
    repeat (20) step();
    drain();
    if (grant_log.size() < s + 4) check("contention_grants", grant_log.size(), s + 4);
    else for (int k = 0; k < 4; k++) check($sformatf("contention_grant_%0d", k), grant_log[s+k], k % 2);

    // Backpressure on port 1 while port 0 keeps requesting.
    ADDRESS[BAW +: BAW] = BAW'(2); ADDRESS_VALID = 2'b10; DATA_READY = 2'b01;
    step();
    ADDRESS[0 +: BAW] = BAW'(3); ADDRESS_VALID = 2'b11;
    wait_valid(1);
    repeat (5) step();
    @(negedge CLK);
    check("backpressure_held", DATA_VALID, 2'b10);
    check("backpressure_no_ready", ADDRESS_READY, 0);
    DATA_READY = 2'b11;
    step();
    drain();

    // Aliasing (5 -> index 1) with a same-edge load to index 1.
    new_blk = rand_block();
    ADDRESS[0 +: BAW] = BAW'(5); ADDRESS_VALID = 2'b01;
    step();
    ADDRESS_VALID = '0;
    step();
    LOAD_VALID = 1'b1; LOAD_ADDRESS = BAW'(1); LOAD_DATA = new_blk;
    step();
    LOAD_VALID = 1'b0;
    @(negedge CLK);
    check("alias_valid", DATA_VALID, 2'b01);
    check("alias_old_data", DATA, pre[1]);
    pre[1] = new_blk;
    step();
    ADDRESS[0 +: BAW] = BAW'(1); ADDRESS_VALID = 2'b01;
    step();
    ADDRESS_VALID = '0;
    wait_valid(0);
    check("alias_new_data", DATA, new_blk);
    drain();

    // Reset during WAIT abandons the transaction.
    ADDRESS[BAW +: BAW] = BAW'(2); ADDRESS_VALID = 2'b10;
    step();
    ADDRESS_VALID = '0; RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (5) step();
    @(negedge CLK);
    check("rst_wait_no_valid", DATA_VALID, 0);
    check("rst_wait_count", REQUEST_COUNT, 0);
    step();
    ADDRESS[0 +: BAW] = BAW'(3); ADDRESS_VALID = 2'b01;
    step();
    ADDRESS_VALID = '0;
    wait_valid(0);
    check("rst_wait_next_data", DATA, pre[3]);
    drain();

    // Randomized traffic, loads and occasional resets.
    repeat (3000) begin
      ADDRESS_VALID = N'($urandom);
      for (int p = 0; p < N; p++) ADDRESS[p*BAW +: BAW] = BAW'($urandom);
      DATA_READY   = N'($urandom);
      LOAD_VALID   = ($urandom % 4) == 0;
      LOAD_ADDRESS = BAW'($urandom);
      LOAD_DATA    = rand_block();
      RST          = ($urandom % 250) == 0;
      step();
    end
    RST = 1'b0;
    drain();
    repeat (4) step();
    @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    check("model_idle", busy, 0);
    check("final_no_valid", DATA_VALID, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_memory_responder.md
L2_MEMORY_RESPONDER -- requirements
Module: l2_memory_responder

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesters (port 0 instruction cache, port 1 data cache).
REQ-002 SHALL have parameter BLOCK_ADDRESS_WIDTH, default 26, width of the block address.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 512, width of a cache block in bits.
REQ-004 SHALL have parameter DEPTH_BLOCKS, default 4, storage depth in blocks (power of 2, >=2).
REQ-005 SHALL have parameter LATENCY, default 2, number of cycles from address acceptance to response (>=1).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port CLK, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-009 SHALL have port ADDRESS_VALID, input, NUM_PORTS, per-port request valid.
REQ-010 SHALL have port ADDRESS_READY, output, NUM_PORTS, per-port request accept.
REQ-011 SHALL have port ADDRESS, input, NUM_PORTS*BLOCK_ADDRESS_WIDTH, per-port block address; port p occupies slice p.
REQ-012 SHALL have port DATA_VALID, output, NUM_PORTS, per-port response valid.
REQ-013 SHALL have port DATA_READY, input, NUM_PORTS, per-port response accept.
REQ-014 SHALL have port DATA, output, BLOCK_WIDTH, response block shared by all ports.
REQ-015 SHALL have port LOAD_VALID, input, 1, preload write enable.
REQ-016 SHALL have port LOAD_ADDRESS, input, BLOCK_ADDRESS_WIDTH, preload block address.
REQ-017 SHALL have port LOAD_DATA, input, BLOCK_WIDTH, preload block data.
REQ-018 SHALL have port REQUEST_COUNT, output, 32, number of completed responses.

Function
REQ-019 SHALL index storage with ADDRESS[log2(DEPTH_BLOCKS)-1:0]; upper bits are ignored (aliasing wrap-around).
REQ-020 SHALL implement the states IDLE, WAIT and RESPOND.
REQ-021 In IDLE, SHALL assert ADDRESS_READY only for the round-robin winner among ports with ADDRESS_VALID high; the search starts at the port after the last granted port.
REQ-022 SHALL accept a request on an edge where ADDRESS_VALID[p] and ADDRESS_READY[p] are both high, latch p and the index, load the counter with LATENCY, and go to WAIT.
REQ-023 In WAIT, SHALL decrement the counter each edge; on the edge where it reaches 0, SHALL read storage into DATA, raise DATA_VALID[p], and go to RESPOND.
REQ-024 As a result, DATA_VALID SHALL first be visible LATENCY edges after the acceptance edge.
REQ-025 In RESPOND, SHALL hold DATA and DATA_VALID[p] stable until DATA_READY[p] is high; on that edge SHALL drop DATA_VALID, increment REQUEST_COUNT, and return to IDLE.
REQ-026 SHALL keep ADDRESS_READY at 0 in WAIT and RESPOND, and SHALL never assert more than one bit of ADDRESS_READY or DATA_VALID.
REQ-027 SHALL write LOAD_DATA to the indexed block on any edge with LOAD_VALID high, in every state.
REQ-028 When a load and a response read hit the same index on the same edge, SHALL return the old contents (read-before-write).
REQ-029 SHALL let REQUEST_COUNT wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 On a RST edge, SHALL enter IDLE and set DATA_VALID=0, DATA=0, REQUEST_COUNT=0, the counter to 0, and the round-robin pointer so that port 0 has highest priority.
REQ-031 SHALL hold ADDRESS_READY=0 while RST is high.
REQ-032 A reset during WAIT or RESPOND SHALL abandon the transaction with no response issued.
REQ-033 SHALL leave storage contents unchanged on reset.

Configuration
REQ-034 With L2_RESPONDER_REQUEST_COUNT_EN defined, REQUEST_COUNT SHALL count as specified; without it, REQUEST_COUNT SHALL be constant 0, no counter register SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-035 Directed test, single request: preload block 1 = pattern A; port 0 requests address 1 with LATENCY=2 and DATA_READY high -> DATA_VALID[0] high exactly 2 edges after acceptance, DATA=A for 1 cycle, REQUEST_COUNT=1.
REQ-036 Directed test, contention: ports 0 and 1 request continuously from reset -> grants go 0,1,0,1; each response appears only on its own port.
REQ-037 Directed test, backpressure: DATA_READY[1] low for 5 cycles during a response -> DATA and DATA_VALID[1] stay stable; no new ADDRESS_READY until the handshake completes.
REQ-038 Directed test, aliasing and collision: request address 5 with DEPTH_BLOCKS=4 -> block 1 returned; a load to index 1 on the read edge -> old data returned and the new data is seen by the next request.
REQ-039 Directed test, reset mid-WAIT: assert RST in WAIT -> no DATA_VALID follows, REQUEST_COUNT=0, and the next request is served normally.
REQ-040 Directed test, macro: build without L2_RESPONDER_REQUEST_COUNT_EN -> REQUEST_COUNT stays 0 after 3 responses.
